// File: rtl/onchip_s2_pkg.sv
// Shared constants, index-width helper and tag-stage type for the s2 arbiter.
package onchip_s2_pkg;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  // Index width for n requesters, never less than 1 bit.
  function automatic int unsigned clog2_req(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/onchip_s2_arbiter_rr.sv
// Combinational round-robin arbiter: rotate requests so the search starts
// just after ptr, pick the lowest set bit, rotate the winner back.
module rr_arbiter
  import onchip_s2_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = clog2_req(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0]     start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int unsigned          first;
  int unsigned          sum;

  // Rotate, priority-encode, rotate back.
  always_comb begin
    start = (ptr == IDX_W'(NUM_REQ - 1)) ? '0 : ptr + IDX_W'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_REQ-1:0];
    any   = |rot;
    first = 0;
    for (int unsigned j = NUM_REQ; j > 0; j--) begin
      if (rot[j-1]) first = j - 1;
    end
    sum = int'(start) + first;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    grant     = NUM_REQ'(any) << sum;
    grant_idx = IDX_W'(sum);
  end

endmodule

// File: rtl/onchip_s2_arbiter.sv
// Round-robin sharing of the on-chip memory s2 port among NUM_REQ requesters,
// with registered s2 commands and fixed-latency read-response routing.
module onchip_s2_arbiter
  import onchip_s2_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned ADDR_W       = 13,
  parameter  int unsigned DATA_W       = 32,
  parameter  int unsigned READ_LATENCY = 1,
  localparam int unsigned BE_W         = DATA_W / 8,
  localparam int unsigned IDX_W        = clog2_req(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*BE_W-1:0]   req_be,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         s2_address,
  output logic                      s2_chipselect,
  output logic                      s2_write,
  output logic [DATA_W-1:0]         s2_writedata,
  output logic [BE_W-1:0]           s2_byteenable,
  output logic                      s2_clken,
  input  logic [DATA_W-1:0]         s2_readdata
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               granted;

  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [BE_W-1:0]    sel_be;
  logic               sel_write;

  tag_t               cmd_tag;
  tag_t               tag_q [READ_LATENCY];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Grants are suppressed while reset is asserted.
  always_comb begin
    req_ack = reset ? '0 : grant;
    granted = grant_any & ~reset;
  end

  // Select the granted requester's command fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_be    = req_be[i*BE_W +: BE_W];
        sel_write = req_write[i];
      end
    end
  end

  // Round-robin pointer follows the last grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (granted) begin
      rr_ptr <= grant_idx;
    end
  end

  // s2 command registers; cmd_tag tracks the read on the bus this cycle so
  // the tag pipeline below lines up with the memory's own readdata latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_address    <= '0;
      s2_chipselect <= 1'b0;
      s2_write      <= 1'b0;
      s2_writedata  <= '0;
      s2_byteenable <= '0;
      cmd_tag       <= '0;
    end else if (granted) begin
      s2_address    <= sel_addr;
      s2_chipselect <= 1'b1;
      s2_write      <= sel_write;
      s2_writedata  <= sel_wdata;
      s2_byteenable <= sel_be;
      cmd_tag.valid <= ~sel_write;
      cmd_tag.idx   <= MAX_IDX_W'(grant_idx);
    end else begin
      s2_chipselect <= 1'b0;
      s2_write      <= 1'b0;
      cmd_tag.valid <= 1'b0;
    end
  end

  // Read tag pipeline, READ_LATENCY stages after the command cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < READ_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= cmd_tag;
      for (int unsigned s = 1; s < READ_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Route the response to its originating requester.
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_q[READ_LATENCY-1].valid &&
                     (tag_q[READ_LATENCY-1].idx == MAX_IDX_W'(i));
    end
    rsp_rdata = s2_readdata;
    s2_clken  = 1'b1;
  end

endmodule
